// File: rtl/dsd_pkg.sv
// Shared definitions for the Dataflow Modeling datapath: controller state
// encoding and the default operand width.
package dsd_pkg;

  localparam int DSD_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

endpackage

// File: rtl/Full_Subtractor.sv
// Single-bit full subtractor: X - Y - BIN, producing a difference bit and a
// borrow-out. Used as the bit-slice of the serial subtractor.
module Full_Subtractor (
  input  logic X,
  input  logic Y,
  input  logic BIN,
  output logic DIFF,
  output logic B_OUT
);

  assign DIFF  = X ^ Y ^ BIN;
  assign B_OUT = (~X & Y) | (~(X ^ Y) & BIN);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial N-bit unsigned subtractor. Operands are captured on START and
// fed LSB-first through one shared Full_Subtractor, one bit per clock; the
// borrow is carried in a register and the difference collects in a shift
// register that is published to DIFF/B_OUT when the MSB has been processed.
module serial_subtractor_ctrl
  import dsd_pkg::*;
#(
  parameter int N = DSD_N
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] DIFF,
  output logic         B_OUT
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] cntLast = CW'(N - 1);

  state_t        state_q;
  logic [N-1:0]  sa_q;
  logic [N-1:0]  sb_q;
  logic [N-1:0]  sd_q;
  logic [N-1:0]  sd_d;
  logic          br_q;
  logic          br_d;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  diff_q;
  logic          bOut_q;

  logic fsDiff;
  logic fsBorrow;

  Full_Subtractor uBitSlice (
    .X    (sa_q[0]),
    .Y    (sb_q[0]),
    .BIN  (br_q),
    .DIFF (fsDiff),
    .B_OUT(fsBorrow)
  );

  // Next result shift value (new difference bit enters at the MSB) and next borrow.
  always_comb begin
    sd_d = (sd_q >> 1) | ({{(N-1){1'b0}}, fsDiff} << (N - 1));
    br_d = fsBorrow;
  end

  // Sequencer: capture on START, shift one bit per clock, publish on the last bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bOut_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            sa_q    <= A;
            sb_q    <= B;
            sd_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          br_q <= br_d;
          sd_q <= sd_d;
          sa_q <= sa_q >> 1;
          sb_q <= sb_q >> 1;
          if (cnt_q == cntLast) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            diff_q  <= sd_d;
            bOut_q  <= br_d;
            state_q <= ST_FIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign DIFF  = diff_q;
  assign B_OUT = bOut_q;

endmodule
